// File: rtl/phase_tag_avg_ctrl.sv
// Phase-tag averaging controller: pops N tags from a FIFO and reports
// their sum, average, min and max, aborting if the FIFO stays empty too long.
module phase_tag_avg_ctrl #(
   parameter int LOG2_N  = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                clk_sample,
   input  logic                rst,
   input  logic                start,
   input  logic [7:0]          fifo_data,
   input  logic                fifo_empty,
   output logic                fifo_rd_en,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [8+LOG2_N-1:0] sum_out,
   output logic [7:0]          avg_out,
   output logic [7:0]          min_out,
   output logic [7:0]          max_out,
   output logic [LOG2_N:0]     count_out,
   output logic                timeout,
   output logic                busy
);

   localparam int SW = 8 + LOG2_N;
   localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0]   TO_C = WW'(TIMEOUT);
   localparam logic [LOG2_N:0] N_C  = (LOG2_N + 1)'(2 ** LOG2_N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_CAPT,
      S_DONE
   } state_t;

   state_t          state_q;
   logic [SW-1:0]   sum_q, sum_d;
   logic [LOG2_N:0] count_q, count_d;
   logic [7:0]      min_q, min_d;
   logic [7:0]      max_q, max_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic            to_q;

   always_comb begin
      sum_d   = sum_q + SW'(fifo_data);
      count_d = count_q + 1'b1;
      min_d   = (fifo_data < min_q) ? fifo_data : min_q;
      max_d   = (fifo_data > max_q) ? fifo_data : max_q;
      wait_d  = wait_q + 1'b1;
   end

   always_ff @(posedge clk_sample) begin
      if (rst) begin
         state_q <= S_IDLE;
         sum_q   <= '0;
         count_q <= '0;
         min_q   <= 8'hFF;
         max_q   <= 8'h00;
         wait_q  <= '0;
         to_q    <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_REQ;
                  sum_q   <= '0;
                  count_q <= '0;
                  min_q   <= 8'hFF;
                  max_q   <= 8'h00;
                  wait_q  <= '0;
                  to_q    <= 1'b0;
               end
            end
            S_REQ: begin
               if (!fifo_empty) begin
                  wait_q  <= '0;
                  state_q <= S_CAPT;
               end else if (wait_q == TO_C) begin
                  to_q    <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  wait_q <= wait_d;
               end
            end
            // Read data arrives one cycle after the REQ-cycle pop.
            S_CAPT: begin
               sum_q   <= sum_d;
               min_q   <= min_d;
               max_q   <= max_d;
               count_q <= count_d;
               state_q <= (count_d == N_C) ? S_DONE : S_REQ;
            end
            S_DONE: begin
               if (out_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign fifo_rd_en = (state_q == S_REQ) && !fifo_empty;
   assign out_valid  = (state_q == S_DONE);
   assign busy       = (state_q != S_IDLE);
   assign sum_out    = sum_q;
   assign avg_out    = sum_q[LOG2_N +: 8];
   assign min_out    = min_q;
   assign max_out    = max_q;
   assign count_out  = count_q;
   assign timeout    = to_q;

endmodule

// File: tb/tb_phase_tag_avg_ctrl.sv
// Directed bench for phase_tag_avg_ctrl: N=4/TIMEOUT=8 instance plus an
// N=16 instance for the full-scale accumulation case.
module tb_phase_tag_avg_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start_a = 1'b0, ready_a = 1'b0;
   logic [7:0] data_a = 8'h00;
   logic       empty_a, rd_a, valid_a, to_a, busy_a;
   logic [9:0] sum_a;
   logic [7:0] avg_a, min_a, max_a;
   logic [2:0] cnt_a;

   logic       start_b = 1'b0, ready_b = 1'b0;
   logic [7:0] data_b = 8'h00;
   logic       empty_b, rd_b, valid_b, to_b, busy_b;
   logic [11:0] sum_b;
   logic [7:0] avg_b, min_b, max_b;
   logic [4:0] cnt_b;

   phase_tag_avg_ctrl #(.LOG2_N(2), .TIMEOUT(8)) dut_a (
      .clk_sample(clk), .rst(rst), .start(start_a),
      .fifo_data(data_a), .fifo_empty(empty_a), .fifo_rd_en(rd_a),
      .out_ready(ready_a), .out_valid(valid_a), .sum_out(sum_a),
      .avg_out(avg_a), .min_out(min_a), .max_out(max_a),
      .count_out(cnt_a), .timeout(to_a), .busy(busy_a)
   );

   phase_tag_avg_ctrl #(.LOG2_N(4)) dut_b (
      .clk_sample(clk), .rst(rst), .start(start_b),
      .fifo_data(data_b), .fifo_empty(empty_b), .fifo_rd_en(rd_b),
      .out_ready(ready_b), .out_valid(valid_b), .sum_out(sum_b),
      .avg_out(avg_b), .min_out(min_b), .max_out(max_b),
      .count_out(cnt_b), .timeout(to_b), .busy(busy_b)
   );

   // FIFO models with one-cycle read latency
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic [7:0] wp_a = 8'd0, rp_a = 8'd0, wp_b = 8'd0, rp_b = 8'd0;
   int rdn_a = 0, rdn_b = 0, viol = 0;
   assign empty_a = (rp_a == wp_a);
   assign empty_b = (rp_b == wp_b);

   always @(posedge clk) begin
      if (rd_a) begin
         data_a <= mem_a[rp_a];
         rp_a   <= rp_a + 8'd1;
         rdn_a  <= rdn_a + 1;
      end
      if (rd_b) begin
         data_b <= mem_b[rp_b];
         rp_b   <= rp_b + 8'd1;
         rdn_b  <= rdn_b + 1;
      end
      if ((rd_a && empty_a) || (rd_b && empty_b)) viol <= viol + 1;
   end

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [7:0] t);
      mem_a[wp_a] = t;
      wp_a = wp_a + 8'd1;
   endtask

   typedef struct {
      int         n;
      logic [7:0] t [4];
      int         sum, avg, mn, mx, cnt, to, lat;
   } vec_t;

   vec_t v [6];

   task automatic setv(input int i, input int n, input int t0, input int t1,
                       input int t2, input int t3, input int sum,
                       input int avg, input int mn, input int mx,
                       input int cnt, input int to, input int lat);
      v[i].n = n;
      v[i].t[0] = 8'(t0);
      v[i].t[1] = 8'(t1);
      v[i].t[2] = 8'(t2);
      v[i].t[3] = 8'(t3);
      v[i].sum = sum; v[i].avg = avg; v[i].mn = mn; v[i].mx = mx;
      v[i].cnt = cnt; v[i].to = to; v[i].lat = lat;
   endtask

   // Waits for out_valid on A, counting ticks since the start edge.
   task automatic wait_a(output int lat);
      lat = 0;
      while (!valid_a && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   task automatic check_a(input string tag, input int sum, input int avg,
                          input int mn, input int mx, input int cnt,
                          input int to);
      chk({tag, ".valid"}, valid_a, 1);
      chk({tag, ".sum"}, sum_a, sum);
      chk({tag, ".avg"}, avg_a, avg);
      chk({tag, ".min"}, min_a, mn);
      chk({tag, ".max"}, max_a, mx);
      chk({tag, ".cnt"}, cnt_a, cnt);
      chk({tag, ".to"}, to_a, to);
   endtask

   initial begin
      int lat, r0;
      logic stable;
      logic [9:0] s_sum;

      setv(0, 4, 10, 20, 30, 41, 101, 25, 10, 41, 4, 0, 8);
      setv(1, 0, 0, 0, 0, 0, 0, 0, 255, 0, 0, 1, 9);
      setv(2, 2, 5, 7, 0, 0, 12, 3, 5, 7, 2, 1, 13);
      setv(3, 4, 255, 0, 128, 1, 384, 96, 0, 255, 4, 0, 8);
      setv(4, 4, 200, 200, 200, 200, 800, 200, 200, 200, 4, 0, 8);
      setv(5, 1, 9, 0, 0, 0, 9, 2, 9, 9, 1, 1, 11);

      // Reset state, with start held to show reset wins
      rst = 1'b1;
      start_a = 1'b1;
      tick();
      tick();
      chk("rst.busy", busy_a, 0);
      chk("rst.valid", valid_a, 0);
      chk("rst.rd", rd_a, 0);
      chk("rst.to", to_a, 0);
      chk("rst.sum", sum_a, 0);
      chk("rst.cnt", cnt_a, 0);
      chk("rst.min", min_a, 8'hFF);
      chk("rst.max", max_a, 8'h00);
      start_a = 1'b0;
      rst = 1'b0;
      tick();

      // Table-driven measurements
      for (int i = 0; i < 6; i++) begin
         string tg;
         tg = $sformatf("v%0d", i);
         for (int k = 0; k < v[i].n; k++) push_a(v[i].t[k]);
         r0 = rdn_a;
         start_a = 1'b1;
         tick();
         start_a = 1'b0;
         chk({tg, ".busy"}, busy_a, 1);
         wait_a(lat);
         chk({tg, ".lat"}, lat, v[i].lat);
         check_a(tg, v[i].sum, v[i].avg, v[i].mn, v[i].mx, v[i].cnt,
                 v[i].to);
         chk({tg, ".rdn"}, rdn_a - r0, v[i].n);
         ready_a = 1'b1;
         tick();
         ready_a = 1'b0;
         chk({tg, ".idle"}, busy_a, 0);
         tick();
         chk({tg, ".hold_sum"}, sum_a, v[i].sum);
      end

      // Back-pressure in DONE with stray start pulses
      for (int k = 1; k <= 4; k++) push_a(8'(k));
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      lat = 2;
      while (!valid_a && lat < 200) begin
         tick();
         lat++;
      end
      chk("bp.lat", lat, 8);
      check_a("bp", 10, 2, 1, 4, 4, 0);
      s_sum = sum_a;
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         start_a = (c % 3 == 0);
         tick();
         if (!valid_a || sum_a != 10'd10 || cnt_a != 3'd4 || min_a != 8'd1
             || max_a != 8'd4 || to_a || avg_a != 8'd2)
            stable = 1'b0;
      end
      chk("bp.stable", stable, 1);
      ready_a = 1'b1;
      start_a = 1'b1;
      tick();
      ready_a = 1'b0;
      start_a = 1'b0;
      chk("bp.idle", busy_a, 0);
      tick();
      chk("bp.drop_start", busy_a, 0);
      chk("bp.hold", sum_a, s_sum);

      // Reset mid-measurement after two of four tags
      push_a(8'd10); push_a(8'd20); push_a(8'd30); push_a(8'd41);
      r0 = rdn_a;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick(); tick(); tick();
      chk("mr.rdn", rdn_a - r0, 2);
      chk("mr.capt_busy", busy_a, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr.busy", busy_a, 0);
      chk("mr.sum", sum_a, 0);
      chk("mr.cnt", cnt_a, 0);
      chk("mr.min", min_a, 8'hFF);
      chk("mr.max", max_a, 8'h00);
      chk("mr.valid", valid_a, 0);
      push_a(8'd50); push_a(8'd60);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_a(lat);
      chk("mr2.lat", lat, 8);
      check_a("mr2", 181, 45, 30, 60, 4, 0);
      ready_a = 1'b1;
      tick();
      ready_a = 1'b0;

      // Full-scale accumulation on the N=16 instance
      for (int k = 0; k < 16; k++) begin
         mem_b[wp_b] = 8'hFF;
         wp_b = wp_b + 8'd1;
      end
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      lat = 0;
      while (!valid_b && lat < 200) begin
         tick();
         lat++;
      end
      chk("big.lat", lat, 32);
      chk("big.valid", valid_b, 1);
      chk("big.sum", sum_b, 12'hFF0);
      chk("big.avg", avg_b, 8'hFF);
      chk("big.min", min_b, 8'hFF);
      chk("big.max", max_b, 8'hFF);
      chk("big.cnt", cnt_b, 16);
      chk("big.to", to_b, 0);
      chk("big.rdn", rdn_b, 16);
      ready_b = 1'b1;
      tick();
      ready_b = 1'b0;
      chk("big.idle", busy_b, 0);

      chk("rd_when_empty", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
